// File: rtl/capture_sequencer_if.sv
// AXI4-Lite bundle between the PS interconnect and capture_sequencer.
interface capture_sequencer_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/capture_sequencer.sv
// AXI4-Lite register block that arms the capture datapath frame by frame,
// counts completed frames and raises a sticky done interrupt.
module capture_sequencer #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FCOUNT_W           = 16
) (
  input  logic               S00_AXI_aclk,
  input  logic               S00_AXI_aresetn,
  capture_sequencer_if.slave s00_axi,
  input  logic               frame_start,
  input  logic               frame_end,
  output logic               enable,
  output logic               irq
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_NFRAMES = 2'd1;
  localparam logic [1:0] A_STATUS  = 2'd2;
  localparam logic [1:0] A_FCOUNT  = 2'd3;

  state_t                        r_state, w_state_nxt;
  logic                          r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]                    r_bresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, w_rdata;
  logic                          r_cont, r_irq_en, r_done, r_aborted, r_abort_pend;
  logic                          r_enable, r_irq;
  logic [FCOUNT_W-1:0]           r_nframes, r_fcount, w_nframes_nxt, w_fcount_nxt;
  logic [FCOUNT_W:0]             w_fcount_inc, w_target;
  logic [31:0]                   w_bmask;
  logic [1:0]                    w_waddr, w_raddr;
  logic                          w_wr, w_rd, w_wr_ctrl, w_wr_nframes, w_wr_status;
  logic                          w_run, w_abort, w_pend_nxt, w_set_done, w_set_aborted;
  logic                          w_done_nxt, w_aborted_nxt, w_cont_nxt, w_irq_en_nxt;
  logic                          w_unused;

  assign w_waddr      = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_raddr      = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_wr         = r_awready & s00_axi.awvalid & s00_axi.wvalid;
  assign w_rd         = r_arready & s00_axi.arvalid;
  assign w_wr_ctrl    = w_wr & (w_waddr == A_CTRL) & s00_axi.wstrb[0];
  assign w_wr_status  = w_wr & (w_waddr == A_STATUS) & s00_axi.wstrb[0];
  assign w_wr_nframes = w_wr & (w_waddr == A_NFRAMES) & (r_state == S_IDLE);
  assign w_run        = w_wr_ctrl & s00_axi.wdata[0];
  assign w_abort      = w_wr_ctrl & s00_axi.wdata[2];
  assign w_unused     = ^{s00_axi.awaddr[1:0], s00_axi.araddr[1:0], s00_axi.wdata, s00_axi.wstrb};

  assign w_bmask = {{8{s00_axi.wstrb[3]}}, {8{s00_axi.wstrb[2]}},
                    {8{s00_axi.wstrb[1]}}, {8{s00_axi.wstrb[0]}}};
  assign w_nframes_nxt = w_wr_nframes
                       ? ((s00_axi.wdata[FCOUNT_W-1:0] & w_bmask[FCOUNT_W-1:0]) |
                          (r_nframes & ~w_bmask[FCOUNT_W-1:0]))
                       : r_nframes;
  assign w_cont_nxt   = w_wr_ctrl ? s00_axi.wdata[1] : r_cont;
  assign w_irq_en_nxt = w_wr_ctrl ? s00_axi.wdata[3] : r_irq_en;

  // NFRAMES of zero still means one frame
  assign w_fcount_inc = {1'b0, r_fcount} + {{FCOUNT_W{1'b0}}, 1'b1};
  assign w_target     = (r_nframes == {FCOUNT_W{1'b0}}) ? {{FCOUNT_W{1'b0}}, 1'b1}
                                                        : {1'b0, r_nframes};

  // Sequencer next state; an abort mid-frame waits for frame_end so no frame is torn
  always_comb begin
    w_state_nxt   = r_state;
    w_fcount_nxt  = r_fcount;
    w_pend_nxt    = r_abort_pend;
    w_set_done    = 1'b0;
    w_set_aborted = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pend_nxt = 1'b0;
        if (w_run && !w_abort) begin
          w_fcount_nxt = {FCOUNT_W{1'b0}};
          w_state_nxt  = S_ARMED;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ARMED: begin
        if (w_abort) begin
          w_set_aborted = 1'b1;
          w_state_nxt   = S_IDLE;
        end else if (frame_start) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_state_nxt = S_ARMED;
        end
      end
      S_CAPTURE: begin
        w_pend_nxt = r_abort_pend | w_abort;
        if (frame_end) begin
          w_fcount_nxt = w_fcount_inc[FCOUNT_W-1:0];
          if ((!r_cont && (w_fcount_inc >= w_target)) || w_pend_nxt) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ARMED;
          end
        end else begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_DONE: begin
        w_set_done    = 1'b1;
        w_set_aborted = r_abort_pend;
        w_pend_nxt    = 1'b0;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Internal sets take priority over a same-cycle W1C
  assign w_done_nxt    = w_set_done | (r_done & ~(w_wr_status & s00_axi.wdata[1]));
  assign w_aborted_nxt = w_set_aborted | (r_aborted & ~(w_wr_status & s00_axi.wdata[2]));

  // Read mux; RUN and ABORT are strobes and always read back as zero
  always_comb begin
    w_rdata = {C_S_AXI_DATA_WIDTH{1'b0}};
    case (w_raddr)
      A_CTRL:    w_rdata[3:0]          = {r_irq_en, 1'b0, r_cont, 1'b0};
      A_NFRAMES: w_rdata[FCOUNT_W-1:0] = r_nframes;
      A_STATUS:  w_rdata[2:0]          = {r_aborted, r_done, (r_state != S_IDLE)};
      A_FCOUNT:  w_rdata[FCOUNT_W-1:0] = r_fcount;
      default:   w_rdata               = {C_S_AXI_DATA_WIDTH{1'b0}};
    endcase
  end

  // Sequencer state, configuration registers and registered outputs
  always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
    if (!S00_AXI_aresetn) begin
      r_state      <= S_IDLE;
      r_cont       <= 1'b0;
      r_irq_en     <= 1'b0;
      r_nframes    <= {FCOUNT_W{1'b0}};
      r_fcount     <= {FCOUNT_W{1'b0}};
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_enable     <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cont       <= w_cont_nxt;
      r_irq_en     <= w_irq_en_nxt;
      r_nframes    <= w_nframes_nxt;
      r_fcount     <= w_fcount_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
      r_abort_pend <= w_pend_nxt;
      r_enable     <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_CAPTURE);
      r_irq        <= w_done_nxt & w_irq_en_nxt;
    end
  end

  // AXI-Lite channel handshakes
  always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
    if (!S00_AXI_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= {C_S_AXI_DATA_WIDTH{1'b0}};
    end else begin
      r_awready <= s00_axi.awvalid & s00_axi.wvalid & ~r_bvalid & ~r_awready;
      r_arready <= s00_axi.arvalid & ~r_rvalid & ~r_arready;
      if (w_wr) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_waddr == A_FCOUNT) ? 2'b10 : 2'b00;
      end else if (s00_axi.bready) begin
        r_bvalid <= 1'b0;
      end else begin
        r_bvalid <= r_bvalid;
      end
      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (s00_axi.rready) begin
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= r_rvalid;
      end
    end
  end

  assign s00_axi.awready = r_awready;
  assign s00_axi.wready  = r_awready;
  assign s00_axi.bvalid  = r_bvalid;
  assign s00_axi.bresp   = r_bresp;
  assign s00_axi.arready = r_arready;
  assign s00_axi.rvalid  = r_rvalid;
  assign s00_axi.rdata   = r_rdata;
  assign s00_axi.rresp   = 2'b00;
  assign enable          = r_enable;
  assign irq             = r_irq;
endmodule
